// File: rtl/pong_pkg.sv
// Shared constants for the Pong match controller: state encoding, serve
// directions, default win score and button width.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned WIN_SCORE_DFLT = 7;
    localparam int unsigned BTN_W          = 2;

endpackage

// File: rtl/pong_press_detect.sv
// Rising-edge detector on the OR of one player's paddle buttons.
module pong_press_detect
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BTN_W-1:0] i_btn,
    output logic             o_press_c
);

    logic r_any;
    logic w_any;

    assign w_any     = |i_btn;
    assign o_press_c = w_any & ~r_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= w_any;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve, play, point pause, game over and scoring.
// Build option PONG_AUTO_SERVE_EN: SERVE auto-launches after PAUSE_FRAMES ticks.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = WIN_SCORE_DFLT,
    parameter int unsigned PAUSE_FRAMES = 120,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [BTN_W-1:0]   btn_left,
    input  logic [BTN_W-1:0]   btn_right,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_o
);

    localparam int unsigned CNT_W = $clog2(PAUSE_FRAMES + 1);
`ifdef PONG_AUTO_SERVE_EN
    localparam bit AUTO_SERVE = 1'b1;
`else
    localparam bit AUTO_SERVE = 1'b0;
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score_left;
    logic [SCORE_W-1:0] r_score_right;
    logic               r_serve_dir;
    logic               r_winner;
    logic               r_ball_run;
    logic               r_ball_reset;
    logic               r_game_over;

    state_t w_state_nxt;
    logic   w_press_l;
    logic   w_press_r;
    logic   w_press_any;
    logic   w_server_press;
    logic   w_cnt_done;
    logic   w_pt_left;
    logic   w_pt_right;
    logic   w_start;
    logic   w_cnt_active;

    pong_press_detect u_press_left (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (btn_left),
        .o_press_c (w_press_l)
    );

    pong_press_detect u_press_right (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (btn_right),
        .o_press_c (w_press_r)
    );

    assign w_press_any    = w_press_l | w_press_r;
    // serve_dir toward the right means the left player is serving
    assign w_server_press = (r_serve_dir == DIR_RIGHT) ? w_press_l : w_press_r;
    assign w_cnt_done     = (r_cnt == '0) || (frame_tick && (r_cnt == CNT_W'(1)));
    assign w_cnt_active   = (r_state == POINT) || (r_state == OVER) ||
                            (AUTO_SERVE && (r_state == SERVE));

    // Next-state and point events
    always_comb begin
        w_state_nxt = r_state;
        w_pt_left   = 1'b0;
        w_pt_right  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press_any) begin
                    w_state_nxt = SERVE;
                    w_start     = 1'b1;
                end
            end
            SERVE: begin
                if (w_server_press || (AUTO_SERVE && w_cnt_done)) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (miss_left) begin
                    w_pt_right  = 1'b1;
                    w_state_nxt = (r_score_right == SCORE_W'(WIN_SCORE - 1)) ? OVER : POINT;
                end else if (miss_right) begin
                    w_pt_left   = 1'b1;
                    w_state_nxt = (r_score_left == SCORE_W'(WIN_SCORE - 1)) ? OVER : POINT;
                end
            end
            POINT: begin
                if (w_cnt_done) begin
                    w_state_nxt = SERVE;
                end
            end
            OVER: begin
                if ((r_cnt == '0) && w_press_any) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, scores, pause counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_score_left  <= '0;
            r_score_right <= '0;
            r_serve_dir   <= DIR_RIGHT;
            r_winner      <= 1'b0;
            r_ball_run    <= 1'b0;
            r_ball_reset  <= 1'b1;
            r_game_over   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ball_run   <= (w_state_nxt == PLAY);
            r_ball_reset <= (w_state_nxt == IDLE) || (w_state_nxt == SERVE) ||
                            (w_state_nxt == OVER);
            r_game_over  <= (w_state_nxt == OVER);

            if (w_start) begin
                r_score_left  <= '0;
                r_score_right <= '0;
                r_serve_dir   <= DIR_RIGHT;
            end
            if (w_pt_right) begin
                r_score_right <= r_score_right + SCORE_W'(1);
                r_serve_dir   <= DIR_RIGHT;
            end
            if (w_pt_left) begin
                r_score_left <= r_score_left + SCORE_W'(1);
                r_serve_dir  <= DIR_LEFT;
            end
            if ((r_state == PLAY) && (w_state_nxt == OVER)) begin
                r_winner <= w_pt_right;
            end

            if (frame_tick && w_cnt_active && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_pt_left || w_pt_right) begin
                r_cnt <= CNT_W'(PAUSE_FRAMES);
            end
            if (AUTO_SERVE && (w_state_nxt == SERVE) && (r_state != SERVE)) begin
                r_cnt <= CNT_W'(PAUSE_FRAMES);
            end
        end
    end

    assign ball_run    = r_ball_run;
    assign ball_reset  = r_ball_reset;
    assign serve_dir   = r_serve_dir;
    assign score_left  = r_score_left;
    assign score_right = r_score_right;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign state_o     = 3'(r_state);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, PAUSE_FRAMES=4.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [1:0] btn_left;
    logic [1:0] btn_right;
    logic       miss_left;
    logic       miss_right;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .WIN_SCORE    (3),
        .PAUSE_FRAMES (4),
        .SCORE_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .ball_run    (ball_run),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .winner      (winner),
        .state_o     (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_l();
        btn_left = 2'b01;
        step();
        btn_left = 2'b00;
        step();
    endtask

    task automatic press_r();
        btn_right = 2'b10;
        step();
        btn_right = 2'b00;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic pulse_miss(input logic ml, input logic mr);
        miss_left  = ml;
        miss_right = mr;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_left   = 2'b00;
        btn_right  = 2'b00;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_state", 32'(state_o), 0);
        check("rst_score_l", 32'(score_left), 0);
        check("rst_score_r", 32'(score_right), 0);
        check("rst_ball_run", 32'(ball_run), 0);
        check("rst_ball_reset", 32'(ball_reset), 1);
        check("rst_serve_dir", 32'(serve_dir), 1);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_winner", 32'(winner), 0);

        // Start: state follows the press by one cycle
        btn_left = 2'b01;
        step();
        check("start_state", 32'(state_o), 1);
        btn_left = 2'b00;
        step();
        check("serve_ball_reset", 32'(ball_reset), 1);
        check("serve_dir_start", 32'(serve_dir), 1);
        check("serve_score_l", 32'(score_left), 0);

        press_r();
        check("nonserver_ignored", 32'(state_o), 1);
`ifndef PONG_AUTO_SERVE_EN
        ticks(5);
        check("serve_waits", 32'(state_o), 1);
`endif
        press_l();
        check("play_state", 32'(state_o), 2);
        check("play_ball_run", 32'(ball_run), 1);
        check("play_ball_reset", 32'(ball_reset), 0);

        pulse_miss(1'b0, 1'b1);
        check("mr_score_l", 32'(score_left), 1);
        check("mr_state", 32'(state_o), 3);
        check("mr_serve_dir", 32'(serve_dir), 0);
        check("point_ball_run", 32'(ball_run), 0);
        check("point_ball_reset", 32'(ball_reset), 0);
        ticks(3);
        check("point_3ticks", 32'(state_o), 3);
        ticks(1);
        check("point_4ticks", 32'(state_o), 1);
        check("serve2_ball_reset", 32'(ball_reset), 1);

        press_l();
        check("serve2_left_ignored", 32'(state_o), 1);
        press_r();
        check("serve2_right_serves", 32'(state_o), 2);

        pulse_miss(1'b1, 1'b1);
        check("both_score_r", 32'(score_right), 1);
        check("both_score_l", 32'(score_left), 1);
        check("both_serve_dir", 32'(serve_dir), 1);
        check("both_state", 32'(state_o), 3);

        ticks(4);
        press_l();
        pulse_miss(1'b1, 1'b0);
        check("ml2_score_r", 32'(score_right), 2);
        ticks(4);
        press_l();
        pulse_miss(1'b1, 1'b0);
        check("win_score_r", 32'(score_right), 3);
        check("win_state", 32'(state_o), 4);
        check("win_game_over", 32'(game_over), 1);
        check("win_winner", 32'(winner), 1);
        check("over_ball_reset", 32'(ball_reset), 1);

        press_l();
        check("over_press_early", 32'(state_o), 4);
        ticks(3);
        press_r();
        check("over_press_3ticks", 32'(state_o), 4);
        ticks(1);
        press_l();
        check("over_to_idle", 32'(state_o), 0);
        check("idle_keeps_score", 32'(score_right), 3);
        press_r();
        check("restart_state", 32'(state_o), 1);
        check("restart_score_r", 32'(score_right), 0);
        check("restart_score_l", 32'(score_left), 0);

        // Reset in the middle of a point pause
        press_l();
        pulse_miss(1'b0, 1'b1);
        check("mid_score_l", 32'(score_left), 1);
        ticks(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_state", 32'(state_o), 0);
        check("midrst_score_l", 32'(score_left), 0);
        check("midrst_ball_reset", 32'(ball_reset), 1);
        ticks(4);
        check("midrst_ticks_idle", 32'(state_o), 0);

`ifdef PONG_AUTO_SERVE_EN
        press_l();
        ticks(3);
        check("auto_3ticks", 32'(state_o), 1);
        ticks(1);
        check("auto_4ticks", 32'(state_o), 2);
        pulse_miss(1'b0, 1'b1);
        ticks(4);
        check("auto_point_done", 32'(state_o), 1);
        ticks(1);
        press_r();
        check("auto_early_press", 32'(state_o), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
